byte_striping_arb: RTL

Two-source arbiter and sequencer for the byte-striping datapath. Round-robin arbitration grants the striping datapath to one of two byte-stream requesters, one packet or burst at a time. Accepted bytes are forwarded with a lane select that alternates lane 0 / lane 1 from the start of each grant. Odd-length grants are padded, so both lanes always carry equal byte counts per grant. The block sits upstream of the byte striper, in the `clk_2f` domain.

---
 rtl/byte_striping_arb.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/byte_striping_arb.sv
// -----------------------------------------------------------------------------
// byte_striping_arb
//
// Two-source round-robin arbiter and sequencer feeding the byte striper.
// One requester owns the datapath for a whole packet (or up to MAX_BURST
// bytes). Accepted bytes go out with a lane select that alternates
// lane 0 / lane 1 from the start of each grant. A grant that ends on lane 0
// is followed by one PAD byte on lane 1, so both lanes see equal byte
// counts per grant.
//
// Ports
//   clk_2f         single clock, rising edge
//   reset          asynchronous, active-low reset
//   req_0/1        requester has a byte on data_0/1
//   data_0/1       requester byte
//   last_0/1       byte is end of packet
//   ack_0/1        byte consumed this cycle (combinational)
//   stripe_ready   downstream striper can take a byte this cycle
//   data_out       byte to striper (registered)
//   valid_out      one-cycle pulse per emitted byte (registered)
//   lane_sel       0 = lane 0, 1 = lane 1 for data_out (registered)
//   grant          one-hot owner, 00 when idle or padding (registered)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate between pending requests by prio
// GNT0  | requester 0 owns the datapath
// GNT1  | requester 1 owns the datapath
// PAD   | grant ended on lane 0; emit PAD on lane 1 when striper ready
// -----------------------------------------------------------------------------

module byte_striping_arb #(
    parameter int                DATA_W    = 8,
    parameter int                MAX_BURST = 16,
    parameter logic [DATA_W-1:0] PAD       = '0
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              req_0,
    input  logic [DATA_W-1:0] data_0,
    input  logic              last_0,
    output logic              ack_0,
    input  logic              req_1,
    input  logic [DATA_W-1:0] data_1,
    input  logic              last_1,
    output logic              ack_1,
    input  logic              stripe_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_sel,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam logic [1:0] ST_PAD  = 2'd3;

    logic [1:0]        r_state;
    logic              r_prio;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_nl;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              r_lane_sel;
    logic [1:0]        r_grant;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_req_prio;
    logic              w_req_other;
    logic [DATA_W-1:0] w_data_sel;
    logic              w_last_sel;
    logic              w_xfer;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_end;
    logic              w_pad_emit;
    logic [1:0]        w_state_nxt;
    logic [1:0]        w_grant_nxt;

    assign w_gnt0 = (r_state == ST_GNT0);
    assign w_gnt1 = (r_state == ST_GNT1);

    assign ack_0 = w_gnt0 & stripe_ready;
    assign ack_1 = w_gnt1 & stripe_ready;

    assign w_req_prio  = r_prio ? req_1 : req_0;
    assign w_req_other = r_prio ? req_0 : req_1;

    // Only the owner's data/last matter; the other side is ignored entirely.
    assign w_data_sel = w_gnt1 ? data_1 : data_0;
    assign w_last_sel = w_gnt1 ? last_1 : last_0;

    assign w_xfer    = ((w_gnt0 & req_0) | (w_gnt1 & req_1)) & stripe_ready;
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // last on the MAX_BURST-th byte collapses into a single grant end.
    assign w_end = w_xfer & (w_last_sel | (w_cnt_inc == CNT_LAST));

    assign w_pad_emit = (r_state == ST_PAD) & stripe_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_prio) begin
                    w_state_nxt = r_prio ? ST_GNT1 : ST_GNT0;
                end else if (w_req_other) begin
                    w_state_nxt = r_prio ? ST_GNT0 : ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                // The ending byte takes lane r_nl; ending on lane 0 means an
                // odd count, so lane 1 still owes a byte.
                if (w_end) begin
                    w_state_nxt = r_nl ? ST_IDLE : ST_PAD;
                end
            end
            ST_PAD: begin
                if (stripe_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // grant is registered alongside the state so it reflects the same edge.
    always_comb begin
        w_grant_nxt = {(w_state_nxt == ST_GNT1), (w_state_nxt == ST_GNT0)};
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_end) begin
                r_prio <= w_gnt0;
            end
        end
    end

    // Burst counter and next-lane bit restart for every grant. Clearing them
    // throughout IDLE is equivalent to clearing on grant entry since no
    // transfer can happen while idle.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_nl  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
            r_nl  <= 1'b0;
        end else if (w_xfer) begin
            r_cnt <= w_cnt_inc;
            r_nl  <= ~r_nl;
        end
    end

    // data_out and lane_sel hold between emissions; valid_out pulses.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_lane_sel  <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_xfer) begin
                r_data_out  <= w_data_sel;
                r_valid_out <= 1'b1;
                r_lane_sel  <= r_nl;
            end else if (w_pad_emit) begin
                r_data_out  <= PAD;
                r_valid_out <= 1'b1;
                r_lane_sel  <= 1'b1;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign lane_sel  = r_lane_sel;
    assign grant     = r_grant;

endmodule
